// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display blocks: scan states,
// default timing constants, digit count and the leading-zero blanking rule.
package sseg_pkg;

  localparam int NUM_DIGITS       = 4;
  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_BLANK_CYCLES = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // A digit is dark when it and every digit above it are zero, unless it is
  // the rightmost digit or its own decimal point is requested.
  function automatic logic digit_suppressed(input logic [1:0]  idx,
                                            input logic [15:0] nibbles,
                                            input logic [3:0]  dps,
                                            input logic        lz);
    logic all_zero;
    all_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx)) all_zero = all_zero & (nibbles[k*4 +: 4] == 4'd0);
    end
    return lz && (idx != 2'd0) && all_zero && !dps[idx];
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Per-digit slot counter. Exposes whether the current cycle ends the slot and
// decodes for the following cycle so the controller can register its outputs
// in step with the count.
module sseg_slot_timer #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic slot_last,
  output logic next_blank,
  output logic next_last
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: held at zero while cleared, wraps after the final slot cycle.
  always_comb begin
    slot_last = (count_q == CW'(REFRESH_DIV - 1));
    count_d   = count_q + CW'(1);
    if (clear || slot_last) count_d = '0;
    next_blank = (count_d < CW'(BLANK_CYCLES));
    next_last  = (count_d == CW'(REFRESH_DIV - 1));
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a double-buffered
// load handshake, frame-aligned display updates and leading-zero blanking.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                  clk,
  input  logic                  btnC,
  input  logic                  en,
  input  logic [15:0]           value,
  input  logic [3:0]            dp_in,
  input  logic                  lz_en,
  input  logic                  load,
  output logic                  ready,
  output logic [NUM_DIGITS-1:0] an,
  output logic [3:0]            hex_digit,
  output logic                  dp_out,
  output logic                  frame_tick
);

  scan_state_e state_q, state_d;
  logic [1:0]  index_q, index_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]  hex_q, hex_d;
  logic        dp_q, dp_d;
  logic        tick_q, tick_d;
  logic        ready_q, ready_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  pend_dp_q, pend_dp_d;

  logic slot_last, next_blank, next_last;
  logic timer_clear;

  // Leaving or sitting in IDLE restarts the slot at count zero.
  assign timer_clear = !en || (state_q == ST_IDLE);

  sseg_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (btnC),
    .clear      (timer_clear),
    .slot_last  (slot_last),
    .next_blank (next_blank),
    .next_last  (next_last)
  );

  // State register plus all registered outputs and data buffers.
  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q     <= en ? ST_BLANK : ST_IDLE;
      index_q     <= 2'd0;
      an_q        <= '1;
      hex_q       <= 4'd0;
      dp_q        <= 1'b1;
      tick_q      <= 1'b0;
      ready_q     <= 1'b1;
      shadow_q    <= 16'd0;
      shadow_dp_q <= 4'd0;
      pend_q      <= 16'd0;
      pend_dp_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      an_q        <= an_d;
      hex_q       <= hex_d;
      dp_q        <= dp_d;
      tick_q      <= tick_d;
      ready_q     <= ready_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
    end
  end

  // Next state and digit index, tracking the slot timer's next count.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    if (!en) begin
      state_d = ST_IDLE;
      index_d = 2'd0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_BLANK;
      index_d = 2'd0;
    end else begin
      if (slot_last) index_d = index_q + 2'd1;
      state_d = next_blank ? ST_BLANK : ST_ON;
    end
  end

  // Output values and the pending/shadow handshake; digit content is latched
  // on ON entry so blanking-mode changes never alter a slot already lit.
  always_comb begin
    an_d        = '1;
    hex_d       = hex_q;
    dp_d        = 1'b1;
    tick_d      = (state_d != ST_IDLE) && next_last && (index_d == 2'd3);
    ready_d     = ready_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;

    if (state_d == ST_ON) begin
      if (state_q == ST_ON) begin
        an_d  = an_q;
        hex_d = hex_q;
        dp_d  = dp_q;
      end else begin
        an_d  = digit_suppressed(index_d, shadow_q, shadow_dp_q, lz_en) ?
                '1 : ~(NUM_DIGITS'(1) << index_d);
        hex_d = shadow_q[{index_d, 2'b00} +: 4];
        dp_d  = ~shadow_dp_q[index_d];
      end
    end

    if (!ready_q && (tick_q || (state_q == ST_IDLE))) begin
      shadow_d    = pend_q;
      shadow_dp_d = pend_dp_q;
      ready_d     = 1'b1;
    end else if (load && ready_q) begin
      pend_d    = value;
      pend_dp_d = dp_in;
      ready_d   = 1'b0;
    end
  end

  assign ready      = ready_q;
  assign an         = an_q;
  assign hex_digit  = hex_q;
  assign dp_out     = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with a small frame scoreboard: each load
// pushes the four expected digit slots, and frame checks pop and compare them.
module tb_sseg_scan_ctrl;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        btnC, en, lz_en, load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        ready, dp_out, frame_tick;
  logic [3:0]  an, hex_digit;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic       dp;
  } slot_exp_t;

  slot_exp_t exp_q[$];

  sseg_scan_ctrl #(
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .btnC       (btnC),
    .en         (en),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .load       (load),
    .ready      (ready),
    .an         (an),
    .hex_digit  (hex_digit),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pushFrame(input logic [15:0] an4, input logic [15:0] hex4, input logic [3:0] dpn4);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{an: an4[i*4 +: 4], hex: hex4[i*4 +: 4], dp: dpn4[i]});
    end
  endtask

  // Drive one load strobe, record the frame it should produce, and confirm
  // the pending buffer reports busy on the following cycle.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp, input logic lz,
                               input logic [15:0] an4, input logic [15:0] hex4,
                               input logic [3:0] dpn4);
    value = v;
    dp_in = dp;
    lz_en = lz;
    load  = 1'b1;
    pushFrame(an4, hex4, dpn4);
    @(negedge clk);
    load = 1'b0;
    checkOutput("ready_after_load", 16'(ready), 16'h0);
  endtask

  task automatic waitTick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $error("[TB] FAIL wait_frame_tick observed=timeout expected=pulse");
    end
  endtask

  task automatic waitDigit2();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (an === 4'b1011) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $error("[TB] FAIL wait_digit2 observed=timeout expected=an_1011");
    end
  endtask

  // Compare one full frame (four slots) against the scoreboard.
  task automatic checkSlots(input bit at_start, input string name);
    slot_exp_t e;
    string     tag;
    for (int s = 0; s < 4; s++) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", name);
        return;
      end
      e = exp_q.pop_front();
      for (int c = 0; c < RDIV; c++) begin
        if (!(at_start && s == 0 && c == 0)) @(negedge clk);
        tag = $sformatf("%s_s%0d_c%0d", name, s, c);
        if (c < BLANK) begin
          checkOutput({tag, "_an"}, 16'(an), 16'hF);
          checkOutput({tag, "_dp"}, 16'(dp_out), 16'h1);
        end else begin
          checkOutput({tag, "_an"}, 16'(an), 16'(e.an));
          checkOutput({tag, "_dp"}, 16'(dp_out), 16'(e.dp));
          if (e.an != 4'hF) checkOutput({tag, "_hex"}, 16'(hex_digit), 16'(e.hex));
        end
        checkOutput({tag, "_tick"}, 16'(frame_tick), 16'((s == 3) && (c == RDIV - 1)));
      end
    end
  endtask

  initial begin
    btnC  = 1'b1;
    en    = 1'b1;
    lz_en = 1'b0;
    load  = 1'b0;
    value = 16'h0;
    dp_in = 4'h0;

    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_an",    16'(an), 16'hF);
    checkOutput("rst_hex",   16'(hex_digit), 16'h0);
    checkOutput("rst_dp",    16'(dp_out), 16'h1);
    checkOutput("rst_tick",  16'(frame_tick), 16'h0);
    checkOutput("rst_ready", 16'(ready), 16'h1);
    btnC = 1'b0;
    @(negedge clk);

    $display("[TB] basic scan of 1234");
    applyStimulus(16'h1234, 4'h0, 1'b0, 16'h7BDE, 16'h1234, 4'hF);
    waitTick();
    checkSlots(1'b0, "f1234");

    $display("[TB] leading-zero blanking of 0050");
    applyStimulus(16'h0050, 4'h0, 1'b1, 16'hFFDE, 16'h0050, 4'hF);
    waitTick();
    checkSlots(1'b0, "lz0050");

    $display("[TB] decimal point keeps a zero digit lit");
    applyStimulus(16'h0000, 4'b0100, 1'b1, 16'hFBFE, 16'h0000, 4'b1011);
    waitTick();
    checkSlots(1'b0, "lz0000dp");

    $display("[TB] busy load ignored");
    applyStimulus(16'hAAAA, 4'h0, 1'b0, 16'h7BDE, 16'hAAAA, 4'hF);
    repeat (3) @(negedge clk);
    value = 16'hBBBB;
    load  = 1'b1;
    checkOutput("ready_busy", 16'(ready), 16'h0);
    @(negedge clk);
    load = 1'b0;
    waitTick();
    checkSlots(1'b0, "fAAAA");

    $display("[TB] reload shows one frame later");
    pushFrame(16'h7BDE, 16'hAAAA, 4'hF);
    applyStimulus(16'hBBBB, 4'h0, 1'b0, 16'h7BDE, 16'hBBBB, 4'hF);
    checkSlots(1'b1, "fAAAA_hold");
    checkSlots(1'b0, "fBBBB");

    $display("[TB] reset during digit 2");
    waitDigit2();
    btnC = 1'b1;
    @(negedge clk);
    btnC = 1'b0;
    checkOutput("mid_rst_an",    16'(an), 16'hF);
    checkOutput("mid_rst_hex",   16'(hex_digit), 16'h0);
    checkOutput("mid_rst_dp",    16'(dp_out), 16'h1);
    checkOutput("mid_rst_ready", 16'(ready), 16'h1);
    checkOutput("mid_rst_tick",  16'(frame_tick), 16'h0);
    pushFrame(16'h7BDE, 16'h0000, 4'hF);
    checkSlots(1'b1, "restart");

    $display("[TB] scan disabled mid-frame with idle load");
    repeat (10) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_an_%0d", i), 16'(an), 16'hF);
      checkOutput($sformatf("idle_tick_%0d", i), 16'(frame_tick), 16'h0);
      if (i == 4) begin
        value = 16'h5678;
        dp_in = 4'h0;
        load  = 1'b1;
        pushFrame(16'h7BDE, 16'h5678, 4'hF);
      end
      if (i == 5) begin
        load = 1'b0;
        checkOutput("idle_ready_busy", 16'(ready), 16'h0);
      end
      if (i == 6) checkOutput("idle_ready_back", 16'(ready), 16'h1);
    end
    en = 1'b1;
    checkSlots(1'b0, "resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 ms at 100 MHz; 4 ms frame).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, meaning leading cycles of each slot with all anodes off; legal range 1 to REFRESH_DIV-1.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports, in order:
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 btnC  in  1  synchronous active-high reset.
REQ-007 en  in  1  scan enable; 0 forces display dark.
REQ-008 value  in  16  four hex digits; [3:0] is digit 0, the rightmost.
REQ-009 dp_in  in  4  decimal-point request per digit, active-high.
REQ-010 lz_en  in  1  leading-zero suppression enable.
REQ-011 load  in  1  valid strobe for value/dp_in.
REQ-012 ready  out  1  pending buffer free; a transfer occurs when load and ready are both 1.
REQ-013 an  out  4  anode selects, active-low.
REQ-014 hex_digit  out  4  nibble for the downstream 7-seg decoder.
REQ-015 dp_out  out  1  decimal point, active-low.
REQ-016 frame_tick  out  1  one-cycle pulse at the end of each frame.

Function
REQ-017 States: IDLE (en=0), BLANK (first BLANK_CYCLES of a slot), ON (remaining cycles of the slot); all outputs registered.
REQ-018 Slot counter SHALL count 0..REFRESH_DIV-1: BLANK while count<BLANK_CYCLES, otherwise ON; at REFRESH_DIV-1 it wraps to 0 and digit index advances 0->1->2->3->0.
REQ-019 In BLANK and IDLE: an=1111, dp_out=1; hex_digit holds its last value.
REQ-020 In ON: an drives low only bit[index] (index 0 -> 1110); hex_digit=shadow nibble[index]; dp_out=~shadow_dp[index].
REQ-021 Leading-zero rule with lz_en=1: digit k (k=3..1) SHALL be suppressed if it and every higher shadow nibble are 0; digit 0 is never suppressed; a suppressed slot keeps an=1111 but still consumes its time.
REQ-022 A suppressed digit with its dp bit set SHALL NOT be suppressed.
REQ-023 Handshake: a cycle with load=1 and ready=1 captures value/dp_in into the pending register and drops ready to 0 on the next cycle; load while ready=0 is ignored.
REQ-024 On the last cycle of the digit-3 slot: frame_tick=1 for that cycle; if pending is full, pending copies to shadow and ready returns to 1 on the next cycle, so the display never tears mid-frame.
REQ-025 If load=1 coincides with the frame-boundary transfer, the load is ignored because ready=0 that cycle.
REQ-026 en 1->0 SHALL enter IDLE next cycle: counter=0, index=0, an=1111, frame_tick=0; pending/shadow/ready are kept and handshake stays live.
REQ-027 While IDLE with pending full, the pending-to-shadow copy SHALL happen on the next cycle and frame_tick SHALL stay 0.
REQ-028 en 0->1 SHALL start at BLANK, count 0, index 0.
REQ-029 lz_en changes SHALL take effect at the next ON entry.

Reset
REQ-030 btnC=1 at any clock edge, mid-slot or mid-handshake, SHALL give next cycle: state BLANK (IDLE if en=0), count=0, index=0, an=1111, hex_digit=0, dp_out=1, frame_tick=0, shadow=0, shadow_dp=0, pending empty, ready=1.
REQ-031 Reset SHALL take priority over load, en and frame-boundary transfer.

Structure
REQ-032 State encodings, the default REFRESH_DIV/BLANK_CYCLES constants and the digit count (4) SHALL live in the shared sseg package/header used by the display blocks.
REQ-033 Slot counter plus wrap/blank decode SHALL be one sub-module, sseg_slot_timer; FSM, handshake and suppression stay in sseg_scan_ctrl.
REQ-034 Counter width SHALL be clog2(REFRESH_DIV); no extra clock dividers or derived clocks.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-035 Reset, en=1, load 16'h1234 dp=0 -> ready low 1 cycle; after first frame_tick, an sequence per slot 1111x2 then 1110x6 with hex 4, then 1101 hex 3, 1011 hex 2, 0111 hex 1.
REQ-036 lz_en=1, value 16'h0050 -> digits 3 and 2 stay dark (an=1111 entire slot); 1101 shows 5; 1110 shows 0.
REQ-037 lz_en=1, value 16'h0000, dp_in=4'b0100 -> only digit 0 (hex 0) and digit 2 (hex 0, dp_out=0) light.
REQ-038 Load 16'hAAAA, then load 16'hBBBB mid-frame -> second ignored (ready=0); AAAA appears only after frame_tick; BBBB reloaded after ready returns displays one frame later.
REQ-039 btnC during ON slot of digit 2 -> next cycle an=1111, hex_digit=0, ready=1; scan restarts at digit 0 with shadow 0.
REQ-040 en=0 for 20 cycles mid-frame -> an=1111 throughout, no frame_tick; en=1 restarts with 2 blank cycles then digit 0.
